// File: rtl/spi_transfer_arbiter_if.sv
// Client/SPI-master side bundle of the transfer arbiter.
// slave: the arbiter; master: clients plus the SPI master.
interface spi_transfer_arbiter_if #(
    parameter int REQUESTERS = 4
);
    logic [REQUESTERS-1:0] request;
    logic [REQUESTERS-1:0] cancel;
    logic [REQUESTERS-1:0] grant;
    logic [REQUESTERS-1:0] done;
    logic [REQUESTERS-1:0] aborted;
    logic                  spi_trigger;
    logic                  spi_abort;
    logic                  spi_busy;
    logic                  spi_complete;

    modport master (
        output request, cancel, spi_busy, spi_complete,
        input  grant, done, aborted, spi_trigger, spi_abort
    );

    modport slave (
        input  request, cancel, spi_busy, spi_complete,
        output grant, done, aborted, spi_trigger, spi_abort
    );
endinterface

// File: rtl/spi_transfer_arbiter.sv
// Round-robin owner of one SPI master: trigger/abort pulses,
// start/transfer timeouts and a guard gap between transfers.
module spi_transfer_arbiter #(
    parameter int REQUESTERS       = 4,
    parameter int START_TIMEOUT    = 8,
    parameter int TRANSFER_TIMEOUT = 64,
    parameter int GAP_TICKS        = 2
) (
    input logic                   clock,
    input logic                   reset,
    spi_transfer_arbiter_if.slave bus
);
    localparam int IW = $clog2(REQUESTERS);
    localparam int M1 = (START_TIMEOUT > TRANSFER_TIMEOUT)
                      ? START_TIMEOUT : TRANSFER_TIMEOUT;
    localparam int MT = (M1 > GAP_TICKS) ? M1 : GAP_TICKS;
    localparam int CW = (MT > 0) ? $clog2(MT + 1) : 1;

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t ST_C = cnt_t'(START_TIMEOUT);
    localparam cnt_t TT_C = cnt_t'(TRANSFER_TIMEOUT);
    localparam logic [IW-1:0] LAST = IW'(REQUESTERS - 1);

    typedef enum logic [2:0] {
        IDLE, TRIGGER, WAIT_START, ACTIVE, ABORT, GAP
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          hit;
    cnt_t          cnt;
    cnt_t          cnt_inc;
    logic          cancel_g;
    int            j;

    // First requester at or after ptr, wrapping.
    always_comb begin
        win = '0;
        hit = 1'b0;
        j   = 0;
        for (int i = 0; i < REQUESTERS; i++) begin
            j = int'(ptr) + i;
            if (j >= REQUESTERS) j = j - REQUESTERS;
            if (!hit && bus.request[j]) begin
                hit = 1'b1;
                win = IW'(j);
            end
        end
    end

    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    assign cancel_g = |(bus.cancel & bus.grant);

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            cnt             <= '0;
            bus.grant       <= '0;
            bus.done        <= '0;
            bus.aborted     <= '0;
            bus.spi_trigger <= 1'b0;
            bus.spi_abort   <= 1'b0;
        end else begin
            bus.done        <= '0;
            bus.aborted     <= '0;
            bus.spi_trigger <= 1'b0;
            bus.spi_abort   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        bus.grant <= REQUESTERS'(1) << win;
                        ptr       <= (win == LAST) ? '0 : win + 1'b1;
                        state     <= TRIGGER;
                    end
                end
                TRIGGER: begin
                    bus.spi_trigger <= 1'b1;
                    cnt             <= '0;
                    state           <= WAIT_START;
                end
                WAIT_START: begin
                    cnt <= cnt_inc;
                    if (bus.spi_busy) begin
                        cnt   <= '0;
                        state <= ACTIVE;
                    end else if (START_TIMEOUT != 0 && cnt == ST_C) begin
                        // Master never started, nothing to abort.
                        bus.aborted <= bus.grant;
                        bus.grant   <= '0;
                        cnt         <= '0;
                        state       <= GAP;
                    end else if (cancel_g) begin
                        bus.aborted   <= bus.grant;
                        bus.spi_abort <= 1'b1;
                        state         <= ABORT;
                    end
                end
                ACTIVE: begin
                    cnt <= cnt_inc;
                    if (bus.spi_complete) begin
                        bus.done  <= bus.grant;
                        bus.grant <= '0;
                        cnt       <= '0;
                        state     <= GAP;
                    end else if (cancel_g ||
                                 (TRANSFER_TIMEOUT != 0 && cnt == TT_C)) begin
                        bus.aborted   <= bus.grant;
                        bus.spi_abort <= 1'b1;
                        state         <= ABORT;
                    end else if (!bus.spi_busy) begin
                        bus.aborted <= bus.grant;
                        bus.grant   <= '0;
                        cnt         <= '0;
                        state       <= GAP;
                    end
                end
                ABORT: begin
                    if (!bus.spi_busy) begin
                        bus.grant <= '0;
                        cnt       <= '0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (int'(cnt) + 1 >= GAP_TICKS) state <= IDLE;
                    else cnt <= cnt_inc;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_transfer_arbiter.sv
// Directed bench for spi_transfer_arbiter with an expected-outcome
// queue popped as each granted transfer ends.
module tb_spi_transfer_arbiter;
    localparam int ST  = 8;
    localparam int TT  = 64;
    localparam int GAP = 2;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] d;
        logic [3:0] a;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n_abort;
    int   n_trig;
    int   n_overlap;
    exp_t sb[$];

    spi_transfer_arbiter_if #(.REQUESTERS(4)) bus ();

    spi_transfer_arbiter #(
        .REQUESTERS(4),
        .START_TIMEOUT(ST),
        .TRANSFER_TIMEOUT(TT),
        .GAP_TICKS(GAP)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_abort   = 0;
        n_trig    = 0;
        n_overlap = 0;
    end

    always @(negedge clk) begin
        if (bus.spi_abort) n_abort <= n_abort + 1;
        if (bus.spi_trigger) n_trig <= n_trig + 1;
        if (!$onehot0(bus.grant)) n_overlap <= n_overlap + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input logic [3:0] exp,
                              output int w);
        w = 0;
        while (bus.grant == 4'b0 && w < 40) begin
            tick();
            w++;
        end
        check("grant", bus.grant, exp);
    endtask

    // mode 0 complete, 1 cancel, 2 no busy, 3 busy stuck, 4 complete+cancel
    task automatic do_transfer(input int mode, input bit drop,
                               input int exp_wait);
        exp_t e;
        int   w;
        int   n;
        int   ab0;
        int   tr0;
        e   = sb.pop_front();
        ab0 = n_abort;
        tr0 = n_trig;
        wait_grant(e.g, w);
        if (exp_wait > 0) check("latency", w, exp_wait);
        if (drop) bus.request = 4'b0;
        tick();
        check("trigger", bus.spi_trigger, 1);
        if (mode == 0 || mode == 4) begin
            bus.spi_busy = 1'b1;
            tick();
            bus.cancel = ~e.g;
            tick();
            tick();
            bus.cancel = (mode == 4) ? e.g : 4'b0;
            bus.spi_complete = 1'b1;
            tick();
            bus.spi_complete = 1'b0;
            bus.spi_busy = 1'b0;
            bus.cancel = 4'b0;
            check("done", bus.done, e.d);
            check("aborted", bus.aborted, e.a);
            check("grant_drop", bus.grant, 0);
            check("abort_now", bus.spi_abort, 0);
        end else if (mode == 1) begin
            bus.spi_busy = 1'b1;
            tick();
            tick();
            tick();
            bus.cancel = e.g;
            tick();
            bus.cancel = 4'b0;
            check("done", bus.done, e.d);
            check("aborted", bus.aborted, e.a);
            check("abort_pulse", bus.spi_abort, 1);
            check("grant_hold", bus.grant, e.g);
            tick();
            check("abort_once", bus.spi_abort, 0);
            tick();
            check("grant_busy", bus.grant, e.g);
            bus.spi_busy = 1'b0;
            tick();
            check("grant_drop", bus.grant, 0);
        end else if (mode == 2) begin
            n = 0;
            while (bus.aborted == 4'b0 && n < 100) begin
                tick();
                n++;
            end
            check("start_to", n, ST + 1);
            check("aborted", bus.aborted, e.a);
            check("done", bus.done, e.d);
            check("grant_drop", bus.grant, 0);
        end else begin
            bus.spi_busy = 1'b1;
            n = 0;
            while (bus.spi_abort == 1'b0 && n < 200) begin
                tick();
                n++;
            end
            check("xfer_to", n, TT + 2);
            check("aborted", bus.aborted, e.a);
            check("grant_hold", bus.grant, e.g);
            bus.spi_busy = 1'b0;
            tick();
            check("grant_drop", bus.grant, 0);
        end
        check("n_abort", n_abort - ab0,
              (mode == 1 || mode == 3) ? 1 : 0);
        check("n_trig", n_trig - tr0, 1);
    endtask

    initial begin
        int w;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.request      = 4'b0;
        bus.cancel       = 4'b0;
        bus.spi_busy     = 1'b0;
        bus.spi_complete = 1'b0;
        tick();
        tick();
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_aborted", bus.aborted, 0);
        check("rst_trig", bus.spi_trigger, 0);
        check("rst_abort", bus.spi_abort, 0);
        rst = 1'b0;
        tick();

        sb.push_back('{g: 4'b0010, d: 4'b0010, a: 4'b0});
        bus.request = 4'b0010;
        do_transfer(0, 1'b1, 1);
        repeat (4) tick();
        check("idle_grant", bus.grant, 0);

        bus.request = 4'b0001;
        wait_grant(4'b0001, w);
        bus.request = 4'b0;
        tick();
        bus.spi_busy = 1'b1;
        repeat (3) tick();
        w = n_abort;
        rst = 1'b1;
        tick();
        check("mid_grant", bus.grant, 0);
        check("mid_done", bus.done, 0);
        check("mid_aborted", bus.aborted, 0);
        check("mid_trig", bus.spi_trigger, 0);
        check("mid_abort", bus.spi_abort, 0);
        rst = 1'b0;
        bus.spi_busy = 1'b0;
        tick();
        check("mid_no_abort", n_abort - w, 0);

        bus.request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{g: 4'b0001 << (k % 4),
                           d: 4'b0001 << (k % 4),
                           a: 4'b0});
            do_transfer(0, 1'b0, (k == 0) ? 1 : GAP + 1);
        end

        sb.push_back('{g: 4'b0100, d: 4'b0, a: 4'b0100});
        bus.request = 4'b0100;
        do_transfer(1, 1'b1, 0);

        sb.push_back('{g: 4'b1000, d: 4'b0, a: 4'b1000});
        bus.request = 4'b1000;
        do_transfer(2, 1'b1, 0);

        sb.push_back('{g: 4'b0001, d: 4'b0, a: 4'b0001});
        bus.request = 4'b0001;
        do_transfer(3, 1'b1, 0);

        sb.push_back('{g: 4'b0010, d: 4'b0010, a: 4'b0});
        bus.request = 4'b0010;
        do_transfer(4, 1'b1, 0);

        repeat (3) tick();
        check("no_overlap", n_overlap, 0);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
